// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - frame buffer scanner: fetches pixel words and streams them to the display driver
// Also hands the front/back buffer swap to the producer at frame boundaries.
module display_scanner #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              swap_req,
  output logic              buf_en,
  output logic              swap_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    SEND      = 3'd3,
    FRAME_END = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              pending;
  logic              stop_lat;
  logic              at_last;
  logic              in_frame_end;

  assign at_last      = (addr_cnt == ADDR_W'(DEPTH - 1));
  assign in_frame_end = (state == FRAME_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = FETCH;
      FETCH:     next_state = LOAD;
      LOAD:      next_state = SEND;
      SEND:      if (pix_ready) next_state = at_last ? FRAME_END : FETCH;
      FRAME_END: next_state = (stop_lat || stop) ? IDLE : FETCH;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    buf_en  = (state == FETCH);
    swap_en = in_frame_end && (pending || swap_req);
    busy    = (state != IDLE);
    r_addr  = addr_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) addr_cnt <= '0;
        LOAD: begin
          pix_data  <= rdata;
          pix_valid <= 1'b1;
          pix_last  <= at_last;
        end
        SEND: if (pix_ready) begin
          pix_valid <= 1'b0;
          pix_last  <= 1'b0;
          if (!at_last) addr_cnt <= addr_cnt + 1'b1;
        end
        FRAME_END: addr_cnt <= '0;
        default: ;
      endcase
    end
  end

  // A swap_req landing in the FRAME_END cycle is consumed by that cycle's swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      overrun  <= 1'b0;
      stop_lat <= 1'b0;
    end else begin
      pending <= (pending || swap_req) && !in_frame_end;
      if (swap_req && pending && !in_frame_end) overrun <= 1'b1;
      if (in_frame_end && next_state == IDLE)   stop_lat <= 1'b0;
      else if (stop && state != IDLE)           stop_lat <= 1'b1;
    end
  end

endmodule
